// File: rtl/bg_pkg.sv
// bg_pkg: shared types and helpers for the background scroll address generator.
//   bg_state_t   - line-walk FSM states
//   BG_ADDR_W    - byte address width into the packed-nibble image
//   BG_COL_W     - column / row / scroll counter width
//   bg_wrap_add  - cur + signed 4-bit step, folded back into [0, modulus)
package bg_pkg;
  localparam int BG_ADDR_W = 23;
  localparam int BG_COL_W  = 10;

  typedef enum logic [1:0] {
    WAIT_FRAME,
    WAIT_LINE,
    LINE
  } bg_state_t;

  // The step magnitude (<= 8) is far below any sane modulus, so a single
  // correction in either direction is always enough.
  function automatic logic [BG_COL_W-1:0] bg_wrap_add(
    input logic [BG_COL_W-1:0] cur,
    input logic [3:0]          step,
    input logic [BG_COL_W-1:0] modulus
  );
    logic [BG_COL_W+1:0] s;
    s = {2'b00, cur} + {{(BG_COL_W-2){step[3]}}, step};
    if (s[BG_COL_W+1])
      s = s + {2'b00, modulus};
    else if (s >= {2'b00, modulus})
      s = s - {2'b00, modulus};
    return s[BG_COL_W-1:0];
  endfunction
endpackage

// File: rtl/bg_wrap_counter.sv
// bg_wrap_counter: loadable up-counter with modulus; counts 0..MOD-1 and wraps.
//   Clk, reset  - clock, synchronous active-high reset (count -> 0)
//   load        - load load_val (has priority over en)
//   load_val    - value to load
//   en          - advance by one, MOD-1 wraps to 0
//   count_nxt   - value the counter takes at the next edge; the parent
//                 registers its own outputs from this so they line up with
//                 the counter instead of lagging it by a cycle
module bg_wrap_counter
  import bg_pkg::*;
#(
  parameter int W   = BG_COL_W,
  parameter int MOD = 640
) (
  input  logic         Clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic [W-1:0] count_nxt
);
  logic [W-1:0] count;

  always_comb begin
    count_nxt = count;
    if (load)
      count_nxt = load_val;
    else if (en)
      count_nxt = (count == W'(MOD-1)) ? '0 : count + 1'b1;
  end

  always_ff @(posedge Clk) begin
    if (reset) count <= '0;
    else       count <= count_nxt;
  end
endmodule

// File: rtl/bg_scroll_addr_gen.sv
// bg_scroll_addr_gen: byte read address into a packed-nibble background image
// (two pixels per byte, even pixel in the high nibble) for the current screen
// pixel, with per-frame horizontal scroll and wrap-around. Row base advances
// by IMG_W/2 per line, so no multiplier.
//   Clk, reset     - clock, synchronous active-high reset
//   frame_start    - frame pulse: applies scroll_step, rewinds to row 0
//   line_start     - line pulse: loads col from scroll_x, advances row
//   pix_en         - advance one pixel (only honoured while walking a line)
//   scroll_step    - signed horizontal scroll delta
//   read_address   - registered byte address to the fetcher
//   nibble_hi      - 1 = high nibble (even column)
//   addr_valid     - registered: walking a visible line
//   scroll_x       - current horizontal scroll
// Optional: define BG_VSCROLL_EN to add scroll_step_y / scroll_y vertical
// scroll; the first row's base is then built by repeated addition while
// waiting for the first line.
module bg_scroll_addr_gen
  import bg_pkg::*;
#(
  parameter int                   IMG_W     = 640,
  parameter int                   IMG_H     = 480,
  parameter int                   LINE_PIX  = 640,
  parameter logic [BG_ADDR_W-1:0] BASE_ADDR = 23'h0
) (
  input  logic                 Clk,
  input  logic                 reset,
  input  logic                 frame_start,
  input  logic                 line_start,
  input  logic                 pix_en,
  input  logic [3:0]           scroll_step,
`ifdef BG_VSCROLL_EN
  input  logic [3:0]           scroll_step_y,
  output logic [8:0]           scroll_y,
`endif
  output logic [BG_ADDR_W-1:0] read_address,
  output logic                 nibble_hi,
  output logic                 addr_valid,
  output logic [BG_COL_W-1:0]  scroll_x
);
  localparam int                   PC_W   = $clog2(LINE_PIX + 1);
  localparam logic [BG_ADDR_W-1:0] HALF_W = BG_ADDR_W'(IMG_W / 2);

  bg_state_t             state, state_nxt;
  logic [BG_COL_W-1:0]   scroll_x_nxt, col_nxt, row_nxt, row_init;
  logic [BG_ADDR_W-1:0]  row_base, rb_nxt;
  logic [PC_W-1:0]       pix_cnt;
  logic                  first_line, first_eff, ls_go, pix_go, pix_last;

  // Frame handling is resolved first, so a coincident line_start sees the
  // new scroll and a freshly set first-line flag.
  assign scroll_x_nxt = frame_start ? bg_wrap_add(scroll_x, scroll_step, BG_COL_W'(IMG_W))
                                    : scroll_x;
  assign first_eff    = frame_start | first_line;
  assign ls_go        = line_start & (frame_start | (state != WAIT_FRAME));
  assign pix_go       = pix_en & (state == LINE) & ~ls_go & ~frame_start;
  assign pix_last     = (pix_cnt == PC_W'(LINE_PIX - 1));

`ifdef BG_VSCROLL_EN
  logic [8:0] scroll_y_nxt, vs_cnt;
  assign scroll_y_nxt = frame_start
    ? 9'(bg_wrap_add({1'b0, scroll_y}, scroll_step_y, BG_COL_W'(IMG_H)))
    : scroll_y;
  assign row_init     = {1'b0, scroll_y_nxt};

  // Rows still to add into row_base before the first line of the frame.
  always_ff @(posedge Clk) begin
    if (reset) begin
      scroll_y <= '0;
      vs_cnt   <= '0;
    end else begin
      scroll_y <= scroll_y_nxt;
      if (frame_start)
        vs_cnt <= scroll_y_nxt;
      else if (state == WAIT_LINE && vs_cnt != '0)
        vs_cnt <= vs_cnt - 1'b1;
    end
  end
`else
  assign row_init = '0;
`endif

  bg_wrap_counter #(.W(BG_COL_W), .MOD(IMG_W)) u_col (
    .Clk      (Clk),
    .reset    (reset),
    .load     (ls_go),
    .load_val (scroll_x_nxt),
    .en       (pix_go),
    .count_nxt(col_nxt)
  );

  bg_wrap_counter #(.W(BG_COL_W), .MOD(IMG_H)) u_row (
    .Clk      (Clk),
    .reset    (reset),
    .load     (frame_start),
    .load_val (row_init),
    .en       (ls_go & ~first_eff),
    .count_nxt(row_nxt)
  );

  // row_nxt == 0 on an advancing line_start means the row just wrapped.
  always_comb begin
    rb_nxt = row_base;
    if (frame_start)
      rb_nxt = BASE_ADDR;
    else if (ls_go && !first_line)
      rb_nxt = (row_nxt == '0) ? BASE_ADDR : row_base + HALF_W;
`ifdef BG_VSCROLL_EN
    else if (state == WAIT_LINE && vs_cnt != '0)
      rb_nxt = row_base + HALF_W;
`endif
  end

  always_comb begin
    state_nxt = state;
    if (frame_start)
      state_nxt = WAIT_LINE;
    if (ls_go)
      state_nxt = LINE;
    else if (pix_go && pix_last)
      state_nxt = WAIT_LINE;
  end

  always_ff @(posedge Clk) begin
    if (reset) state <= WAIT_FRAME;
    else       state <= state_nxt;
  end

  always_ff @(posedge Clk) begin
    if (reset) begin
      scroll_x     <= '0;
      first_line   <= 1'b0;
      pix_cnt      <= '0;
      row_base     <= '0;
      read_address <= '0;
      nibble_hi    <= 1'b1;
      addr_valid   <= 1'b0;
    end else begin
      scroll_x <= scroll_x_nxt;
      if (ls_go)
        first_line <= 1'b0;
      else if (frame_start)
        first_line <= 1'b1;
      if (ls_go)
        pix_cnt <= '0;
      else if (pix_go)
        pix_cnt <= pix_cnt + 1'b1;
      row_base     <= rb_nxt;
      read_address <= rb_nxt + {{(BG_ADDR_W-BG_COL_W+1){1'b0}}, col_nxt[BG_COL_W-1:1]};
      nibble_hi    <= ~col_nxt[0];
      addr_valid   <= (state_nxt == LINE);
    end
  end
endmodule

// File: tb/tb_bg_scroll_addr_gen.sv
module tb_bg_scroll_addr_gen;
  logic        Clk = 1'b0;
  logic        reset = 1'b1, frame_start = 1'b0, line_start = 1'b0, pix_en = 1'b0;
  logic [3:0]  scroll_step = '0;
  logic [22:0] read_address;
  logic        nibble_hi, addr_valid;
  logic [9:0]  scroll_x;
`ifdef BG_VSCROLL_EN
  logic [3:0]  scroll_step_y = '0;
  logic [8:0]  scroll_y;
`endif

  typedef struct {
    string tag;
    logic  ca;
    int    addr;
    logic  nib;
    logic  vld;
    int    sx;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0, n_err = 0;

  bg_scroll_addr_gen dut (
    .Clk         (Clk),
    .reset       (reset),
    .frame_start (frame_start),
    .line_start  (line_start),
    .pix_en      (pix_en),
    .scroll_step (scroll_step),
`ifdef BG_VSCROLL_EN
    .scroll_step_y(scroll_step_y),
    .scroll_y    (scroll_y),
`endif
    .read_address(read_address),
    .nibble_hi   (nibble_hi),
    .addr_valid  (addr_valid),
    .scroll_x    (scroll_x)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Scoreboard consumer: one expectation per driven cycle, checked just
  // after the edge that consumed that cycle's inputs.
  always @(posedge Clk) begin
    #1;
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk({e.tag, ".vld"}, 32'(addr_valid), 32'(e.vld));
      chk({e.tag, ".sx"},  32'(scroll_x),   e.sx);
      if (e.ca) begin
        chk({e.tag, ".addr"}, 32'(read_address), e.addr);
        chk({e.tag, ".nib"},  32'(nibble_hi),    32'(e.nib));
      end
    end
  end

  task automatic step(input string tag, input logic rs, fs, ls, pe, input int st,
                      input logic ca, input int ea, input logic en, ev, input int esx);
    exp_t e;
    @(negedge Clk);
    reset = rs; frame_start = fs; line_start = ls; pix_en = pe;
    scroll_step = 4'(st);
    e.tag = tag; e.ca = ca; e.addr = ea; e.nib = en; e.vld = ev; e.sx = esx;
    q.push_back(e);
  endtask

  // pix_en followed by an idle cycle; the address must hold across both.
  task automatic pix(input string tag, input int ea, input logic en, input int esx);
    step(tag, 0, 0, 0, 1, 0, 1, ea, en, 1, esx);
    step(tag, 0, 0, 0, 0, 0, 1, ea, en, 1, esx);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    // reset state
    step("rst", 1, 0, 0, 0, 0, 1, 0, 1, 0, 0);
    step("rst", 1, 0, 0, 0, 0, 1, 0, 1, 0, 0);
    // step 0, first line, two pixels
    step("t1fs", 0, 1, 0, 0, 0, 1, 0, 1, 0, 0);
    step("t1ls", 0, 0, 1, 0, 0, 1, 0, 1, 1, 0);
    pix("t1p1", 0, 0, 0);
    pix("t1p2", 1, 1, 0);
    // 0 - 2 wraps to 638
    step("t3fs", 0, 1, 0, 0, -2, 0, 0, 0, 0, 638);
    step("t3ls", 0, 0, 1, 0, 0, 1, 319, 1, 1, 638);
    pix("t3p1", 319, 0, 638);
    pix("t3p2", 0, 1, 638);
    // 638 + 3 wraps to 1
    step("t2fs", 0, 1, 0, 0, 3, 0, 0, 0, 0, 1);
    step("t2ls", 0, 0, 1, 0, 0, 1, 0, 0, 1, 1);
    // back to 0; row advance, full line, row wrap
    step("t4fs", 0, 1, 0, 0, -1, 0, 0, 0, 0, 0);
    step("t4l0", 0, 0, 1, 0, 0, 1, 0, 1, 1, 0);
    step("t4l1", 0, 0, 1, 0, 0, 1, 320, 1, 1, 0);
    for (int k = 1; k < 640; k++)
      pix("t4pix", 320 + k / 2, (k % 2) == 0, 0);
    step("t4end", 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    step("t4end", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step("t4ign", 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    for (int r = 2; r < 480; r++)
      step("t4row", 0, 0, 1, 0, 0, 1, r * 320, 1, 1, 0);
    step("t4wrap", 0, 0, 1, 0, 0, 1, 0, 1, 1, 0);
    // coincident frame_start and line_start
    step("t5", 0, 1, 1, 0, 0, 1, 0, 1, 1, 0);
    // reset mid-line after 100 pixels
    step("t6fs", 0, 1, 0, 0, 5, 0, 0, 0, 0, 5);
    step("t6ls", 0, 0, 1, 0, 0, 1, 2, 0, 1, 5);
    for (int k = 1; k <= 100; k++)
      pix("t6pix", (5 + k) / 2, ((5 + k) % 2) == 0, 5);
    step("t6rst", 1, 0, 0, 0, 0, 1, 0, 1, 0, 0);
    step("t6ign", 0, 0, 0, 1, 0, 1, 0, 1, 0, 0);
    step("t6ign", 0, 0, 0, 0, 0, 1, 0, 1, 0, 0);
    step("t6ign", 0, 0, 0, 1, 0, 1, 0, 1, 0, 0);
    step("t6ls",  0, 0, 1, 0, 0, 1, 0, 1, 0, 0);
    @(negedge Clk);
    pix_en = 0; line_start = 0;
    @(negedge Clk);
    chk("drain", 32'(q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/bg_scroll_addr_gen.md
# bg_scroll_addr_gen

Generates the byte read address into the packed-nibble background image (two 4-bit pixels per byte, even pixel in the high nibble) for the current screen pixel, applying a per-frame horizontal scroll with wrap-around. Sits directly upstream of the two-phase background byte fetcher, which registers `read_address`, fetches one byte, and splits it into two palette indices. Row base is maintained incrementally, so no multiplier is needed.

## Interface
- `IMG_W`, 640: image width in pixels; even, at most 1023.
- `IMG_H`, 480: image height in lines.
- `LINE_PIX`, 640: visible pixels per line.
- `BASE_ADDR`, 23'h0: byte address of image pixel (0,0).
- `Clk` in 1: system clock.
- `reset` in 1: synchronous, active-high.
- `frame_start` in 1: one-cycle pulse at the start of each frame.
- `line_start` in 1: one-cycle pulse before pixel 0 of each visible line.
- `pix_en` in 1: advance one pixel.
- `scroll_step` in 4, signed: horizontal scroll delta applied at `frame_start`.
- `read_address` out 23: byte address to the fetcher.
- `nibble_hi` out 1: 1 selects the high nibble (even column).
- `addr_valid` out 1: `read_address` is meaningful.
- `scroll_x` out 10: current horizontal scroll in pixels.

## Operation
- FSM `WAIT_FRAME` → `WAIT_LINE` → `LINE`.
  - `frame_start` in any state goes to `WAIT_LINE`.
  - `line_start` in `WAIT_LINE` goes to `LINE`.
  - `LINE` returns to `WAIT_LINE` after `LINE_PIX` accepted `pix_en`.
  - `line_start` while in `LINE` restarts the line.
- At `frame_start`:
  - s = `scroll_x` + `scroll_step`. If s < 0, add `IMG_W`; if s ≥ `IMG_W`, subtract `IMG_W`.
  - `row` ← 0 and `row_base` ← `BASE_ADDR`, and a first-line flag is set.
- At `line_start`:
  - If the first-line flag is set, clear it and leave `row_base` unchanged.
  - Otherwise `row` ← `row`+1 and `row_base` += `IMG_W`/2.
  - When `row` reaches `IMG_H`, it wraps to 0 and `row_base` returns to `BASE_ADDR`.
  - In both cases `col` ← `scroll_x` and the pixel count ← 0.
- `pix_en` in `LINE`: `col` ← `col`+1, wrapping `IMG_W`-1 → 0; the pixel count increments. `pix_en` outside `LINE` is ignored.
- Outputs (registered):
  - `read_address` = `row_base` + (`col` >> 1).
  - `nibble_hi` = ~`col`[0].
  - `addr_valid` = (state == `LINE`).
- If `frame_start` and `line_start` coincide, frame handling happens first, then line 0 begins immediately: state → `LINE`, row 0, `col` = new `scroll_x`.
- All additions are done at full 23-bit width. The address never wraps past `BASE_ADDR` + `IMG_W`·`IMG_H`/2 − 1.

## Timing
- Reset values:
  - State `WAIT_FRAME`; `read_address` 0; `nibble_hi` 1; `addr_valid` 0; `scroll_x` 0.
  - `row`, `col` and `row_base` internal registers are also cleared.
- Reset mid-line takes effect on the next edge: `addr_valid` drops to 0, and `scroll_x` is lost.
- Latency:
  - One cycle from `line_start` to the first valid address.
  - One cycle from `pix_en` to the updated address.
- Outputs hold between `pix_en` pulses. The downstream fetcher needs each address stable for ≥2 cycles, so the driver spaces `pix_en` at least 2 cycles apart. The block does not check this spacing.
- `scroll_x` updates one cycle after `frame_start` and is constant for the rest of the frame.

## Configuration
- `BG_VSCROLL_EN` defined:
  - Adds input `scroll_step_y` (4, signed) and output `scroll_y` (9).
  - At `frame_start`, `scroll_y` updates modulo `IMG_H` with the same wrap rules as `scroll_x`.
  - The first line starts at `row` = `scroll_y`, with `row_base` = `BASE_ADDR` + `scroll_y`·(`IMG_W`/2), computed over `scroll_y` cycles of repeated addition while in `WAIT_LINE`. That is complete before any legal `line_start`.
- `BG_VSCROLL_EN` undefined: these ports are absent and the first line always starts at row 0.

## Structure
- Package `bg_pkg` holds:
  - the state enum `bg_state_t`;
  - `BG_ADDR_W` = 23;
  - `BG_COL_W` = 10;
  - a `bg_wrap_add` function for the modular scroll update.
- Sub-module `bg_wrap_counter`: a loadable counter with modulus, enable and wrap, used for `col` and `row`.

## Test plan
All scenarios use default parameters.
- Reset, `frame_start` with step 0, `line_start`, then two `pix_en` → (address, `nibble_hi`) goes 0/1, then 0/0, then 1/1, with `addr_valid` 1.
- `scroll_x` = 638, step +3 at `frame_start` → `scroll_x` = 1; first address of line 0 is 0 with `nibble_hi` 0.
- `scroll_x` = 0, step −2 → `scroll_x` = 638; first address 319 with `nibble_hi` 1; after two `pix_en`, address 0 with `nibble_hi` 1.
- Second `line_start` with `scroll_x` = 0 → first address 320. After 480 lines, the next `line_start` without `frame_start` gives address 0.
- `frame_start` and `line_start` in the same cycle → one cycle later `addr_valid` 1 and address 0 (with step 0, `scroll_x` 0).
- Reset asserted after 100 `pix_en` → next edge gives `addr_valid` 0, `read_address` 0 and `scroll_x` 0. `pix_en` before the next `frame_start` causes no change.
